rv32_uart_tx: RTL and testbench

- Memory-mapped UART transmitter in the peripheral region at base 0x20000000, downstream of the core's memory stage.
- Consumes byte-enable store traffic (we/addr/wdata) and returns registered read data on the same bus.
- Buffers bytes in a FIFO and serialises them 8N1 (optionally 8E1) onto uart_tx_o.

---
 rtl/rv32_uart_pkg.sv | 25 ++
 rtl/rv32_sync_fifo.sv | 54 +++++
 rtl/rv32_uart_tx.sv | 219 +++++++++++++++++++++
 tb/tb_rv32_uart_tx.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_uart_pkg.sv
// Shared types and register map for the rv32 UART blocks.
package rv32_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic [1:0] UART_TXDATA  = 2'd0;
  localparam logic [1:0] UART_STATUS  = 2'd1;
  localparam logic [1:0] UART_BAUDDIV = 2'd2;

  localparam int unsigned STAT_FULL    = 0;
  localparam int unsigned STAT_EMPTY   = 1;
  localparam int unsigned STAT_BUSY    = 2;
  localparam int unsigned STAT_OVF     = 3;
  localparam int unsigned STAT_PAR_EN  = 4;
  localparam int unsigned STAT_CNT_LSB = 8;

  localparam int unsigned BAUD_W = 16;

endpackage

// File: rtl/rv32_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module rv32_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/rv32_uart_tx.sv
// Memory-mapped UART transmitter: FIFO-buffered 8N1 serialiser.
// Define RV32_UART_TX_PARITY_EN to add the STATUS[4] even-parity (8E1) option.
module rv32_uart_tx
  import rv32_uart_pkg::*;
#(
  parameter int unsigned  FIFO_DEPTH     = 16,
  parameter logic [15:0]  BAUD_DIV_RESET = 16'd867
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        sel_i,
  input  logic [3:0]  mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_data_o,
  output logic        uart_tx_o,
  output logic        irq_o
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  tx_state_t          r_state, w_state_nxt;
  logic [7:0]         r_shift, w_shift_nxt;
  logic [BAUD_W-1:0]  r_reload, w_reload_nxt;
  logic [BAUD_W-1:0]  r_cnt, w_cnt_nxt;
  logic [2:0]         r_idx, w_idx_nxt;
  logic               r_tx, w_tx_nxt;
  logic [BAUD_W-1:0]  r_baud;
  logic               r_ovf;
  logic [31:0]        r_rdata;
  logic               r_irq;
`ifdef RV32_UART_TX_PARITY_EN
  logic               r_par_en;
  logic               r_par_frame, w_par_frame_nxt;
`endif

  logic               w_write;
  logic [1:0]         w_off;
  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic [CW-1:0]      w_count;
  logic [7:0]         w_fifo_data;
  logic               w_bit_done;
  logic [31:0]        w_status;
  logic [31:0]        w_rdata;
  logic               w_unused;

  assign w_write    = sel_i & (|mem_we_i);
  assign w_off      = mem_addr_i[3:2];
  assign w_push     = w_write & (w_off == UART_TXDATA);
  assign w_bit_done = (r_cnt == '0);
  assign w_unused   = ^{mem_addr_i[31:4], mem_addr_i[1:0], mem_data_i[31:16]};

  rv32_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (clk_i),
    .i_rst   (rst_i),
    .i_push  (w_push),
    .i_wdata (mem_data_i[7:0]),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic; uart_tx_o is the registered copy of w_tx_nxt.
  always_comb begin
    w_state_nxt  = r_state;
    w_shift_nxt  = r_shift;
    w_reload_nxt = r_reload;
    w_cnt_nxt    = r_cnt;
    w_idx_nxt    = r_idx;
    w_tx_nxt     = r_tx;
    w_pop        = 1'b0;
`ifdef RV32_UART_TX_PARITY_EN
    w_par_frame_nxt = r_par_frame;
`endif
    case (r_state)
      IDLE: begin
        w_tx_nxt = 1'b1;
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_shift_nxt  = w_fifo_data;
          w_reload_nxt = r_baud;
          w_cnt_nxt    = r_baud;
          w_tx_nxt     = 1'b0;
          w_state_nxt  = START;
`ifdef RV32_UART_TX_PARITY_EN
          w_par_frame_nxt = r_par_en;
`endif
        end
      end
      START: begin
        if (w_bit_done) begin
          w_state_nxt = DATA;
          w_idx_nxt   = 3'd0;
          w_cnt_nxt   = r_reload;
          w_tx_nxt    = r_shift[0];
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      DATA: begin
        if (w_bit_done) begin
          w_cnt_nxt = r_reload;
          if (r_idx == 3'd7) begin
            w_state_nxt = STOP;
            w_tx_nxt    = 1'b1;
`ifdef RV32_UART_TX_PARITY_EN
            if (r_par_frame) begin
              w_state_nxt = PARITY;
              w_tx_nxt    = ^r_shift;
            end
`endif
          end else begin
            w_idx_nxt = r_idx + 3'd1;
            w_tx_nxt  = r_shift[r_idx + 3'd1];
          end
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
`ifdef RV32_UART_TX_PARITY_EN
      PARITY: begin
        if (w_bit_done) begin
          w_state_nxt = STOP;
          w_cnt_nxt   = r_reload;
          w_tx_nxt    = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
`endif
      STOP: begin
        if (w_bit_done) w_state_nxt = IDLE;
        else            w_cnt_nxt   = r_cnt - 1'b1;
      end
      default: begin
        w_state_nxt = IDLE;
        w_tx_nxt    = 1'b1;
      end
    endcase
  end

  always_comb begin
    w_status                       = '0;
    w_status[STAT_FULL]            = w_full;
    w_status[STAT_EMPTY]           = w_empty;
    w_status[STAT_BUSY]            = (r_state != IDLE);
    w_status[STAT_OVF]             = r_ovf;
    w_status[STAT_CNT_LSB +: 8]    = 8'(w_count);
`ifdef RV32_UART_TX_PARITY_EN
    w_status[STAT_PAR_EN]          = r_par_en;
`endif
  end

  always_comb begin
    w_rdata = '0;
    case (w_off)
      UART_STATUS:  w_rdata = w_status;
      UART_BAUDDIV: w_rdata = {16'd0, r_baud};
      default:      w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_shift  <= '0;
      r_reload <= '0;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_tx     <= 1'b1;
      r_baud   <= BAUD_DIV_RESET;
      r_ovf    <= 1'b0;
      r_rdata  <= '0;
      r_irq    <= 1'b1;
`ifdef RV32_UART_TX_PARITY_EN
      r_par_en    <= 1'b0;
      r_par_frame <= 1'b0;
`endif
    end else begin
      r_shift  <= w_shift_nxt;
      r_reload <= w_reload_nxt;
      r_cnt    <= w_cnt_nxt;
      r_idx    <= w_idx_nxt;
      r_tx     <= w_tx_nxt;
      r_rdata  <= sel_i ? w_rdata : 32'd0;
      r_irq    <= w_empty & (r_state == IDLE);
`ifdef RV32_UART_TX_PARITY_EN
      r_par_frame <= w_par_frame_nxt;
`endif
      // A push into a full FIFO is only lost when no pop frees a slot.
      if (w_push && w_full && !w_pop) begin
        r_ovf <= 1'b1;
      end else if (w_write && (w_off == UART_STATUS) && mem_data_i[STAT_OVF]) begin
        r_ovf <= 1'b0;
      end
      if (w_write && (w_off == UART_BAUDDIV)) r_baud <= mem_data_i[15:0];
`ifdef RV32_UART_TX_PARITY_EN
      if (w_write && (w_off == UART_STATUS)) r_par_en <= mem_data_i[STAT_PAR_EN];
`endif
    end
  end

  assign mem_data_o = r_rdata;
  assign uart_tx_o  = r_tx;
  assign irq_o      = r_irq;

endmodule

// File: tb/tb_rv32_uart_tx.sv
// Self-checking bench for rv32_uart_tx: register table, directed frame
// sequences and randomized traffic against a frame-level reference model.
module tb_rv32_uart_tx;

  localparam int unsigned DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        sel;
  logic [3:0]  we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        tx;
  logic        irq;

  int checks;
  int errors;
  int unsigned cyc;

  rv32_uart_tx #(
    .FIFO_DEPTH     (DEPTH),
    .BAUD_DIV_RESET (16'd867)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .sel_i      (sel),
    .mem_we_i   (we),
    .mem_addr_i (addr),
    .mem_data_i (wdata),
    .mem_data_o (rdata),
    .uart_tx_o  (tx),
    .irq_o      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: byte queue plus the timeline of the frame on the line.
  byte unsigned mq[$];
  int unsigned  m_fstart;
  int unsigned  m_nbits;
  int unsigned  m_period;
  bit           m_bits[11];
  logic [15:0]  m_baud;
  bit           m_ovf;
  bit           m_par_en;
  logic [31:0]  m_rdata;
  bit           m_irq;

  function automatic bit m_busy();
    return cyc < m_fstart + m_nbits * m_period;
  endfunction

  function automatic bit m_line();
    if (m_busy() && cyc >= m_fstart) return m_bits[(cyc - m_fstart) / m_period];
    return 1'b1;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    logic [31:0] s;
    s = '0;
    case (a[3:2])
      2'd1: begin
        s[0]    = (mq.size() == DEPTH);
        s[1]    = (mq.size() == 0);
        s[2]    = m_busy();
        s[3]    = m_ovf;
`ifdef RV32_UART_TX_PARITY_EN
        s[4]    = m_par_en;
`endif
        s[15:8] = 8'(mq.size());
      end
      2'd2:    s = {16'd0, m_baud};
      default: s = '0;
    endcase
    return s;
  endfunction

  task automatic m_step(input logic r, input logic s, input logic [3:0] w,
                        input logic [31:0] a, input logic [31:0] d);
    logic [31:0]  nrd;
    bit           nirq;
    byte unsigned b;
    int unsigned  n;
    if (r) begin
      mq.delete();
      m_fstart = cyc + 1; m_nbits = 0; m_period = 1;
      m_baud = 16'd867; m_ovf = 0; m_par_en = 0;
      m_rdata = '0; m_irq = 1;
    end else begin
      nrd  = s ? m_read(a) : 32'd0;
      nirq = (mq.size() == 0) && !m_busy();
      if (!m_busy() && mq.size() > 0) begin
        b = mq.pop_front();
        m_fstart = cyc + 1;
        m_period = 32'(m_baud) + 1;
        m_bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) m_bits[i+1] = b[i];
        n = 9;
        if (m_par_en) begin
          m_bits[9] = ^b;
          n = 10;
        end
        m_bits[n] = 1'b1;
        m_nbits = n + 1;
      end
      if (s && w != 4'd0) begin
        case (a[3:2])
          2'd0: if (mq.size() < DEPTH) mq.push_back(d[7:0]); else m_ovf = 1;
          2'd1: begin
            if (d[3]) m_ovf = 0;
`ifdef RV32_UART_TX_PARITY_EN
            m_par_en = d[4];
`endif
          end
          2'd2: m_baud = d[15:0];
          default: ;
        endcase
      end
      m_rdata = nrd;
      m_irq   = nirq;
    end
    cyc++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic [3:0] w,
                      input logic [31:0] a, input logic [31:0] d);
    rst = r; sel = s; we = w; addr = a; wdata = d;
    m_step(r, s, w, a, d);
    @(posedge clk);
    @(negedge clk);
    check("model_tx", 32'(tx), 32'(m_line()));
    check("model_irq", 32'(irq), 32'(m_irq));
    check("model_rdata", rdata, m_rdata);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
  endtask

  task automatic wr(input logic [1:0] off, input logic [31:0] d);
    step(1'b0, 1'b1, 4'hf, {28'h2000000, off, 2'b00}, d);
  endtask

  task automatic rd(input logic [1:0] off);
    step(1'b0, 1'b1, 4'd0, {28'h2000000, off, 2'b00}, 32'd0);
  endtask

  typedef struct {
    bit          sel;
    logic [3:0]  we;
    logic [1:0]  off;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t        tbl[12];
  logic [9:0]  a5_frame;
  int          len;

  initial begin
    checks = 0; errors = 0; cyc = 0;
    rst = 1; sel = 0; we = 0; addr = 0; wdata = 0;
    a5_frame = {1'b1, 8'hA5, 1'b0};
    @(negedge clk);

    // Reset state
    step(1'b1, 1'b0, 4'd0, 32'd0, 32'd0);
    step(1'b1, 1'b0, 4'd0, 32'd0, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_irq", 32'(irq), 32'd1);
    rd(2'd1);
    check("rst_status", rdata, 32'h0000_0002);

    // Register table: expected read data registered from the pre-write value
    tbl[0]  = '{1'b1, 4'h0, 2'd2, 32'h0,         32'h0000_0363};
    tbl[1]  = '{1'b1, 4'hf, 2'd2, 32'hABCD_1234, 32'h0000_0363};
    tbl[2]  = '{1'b1, 4'h0, 2'd2, 32'h0,         32'h0000_1234};
    tbl[3]  = '{1'b1, 4'hf, 2'd3, 32'hFFFF_FFFF, 32'h0};
    tbl[4]  = '{1'b1, 4'h0, 2'd3, 32'h0,         32'h0};
    tbl[5]  = '{1'b1, 4'h0, 2'd0, 32'h0,         32'h0};
    tbl[6]  = '{1'b0, 4'h0, 2'd2, 32'h0,         32'h0};
    tbl[7]  = '{1'b0, 4'hf, 2'd2, 32'h5,         32'h0};
    tbl[8]  = '{1'b1, 4'h0, 2'd2, 32'h0,         32'h0000_1234};
    tbl[9]  = '{1'b1, 4'h1, 2'd2, 32'h3,         32'h0000_1234};
    tbl[10] = '{1'b1, 4'h0, 2'd2, 32'h0,         32'h0000_0003};
    tbl[11] = '{1'b1, 4'h0, 2'd1, 32'h0,         32'h0000_0002};
    for (int i = 0; i < 12; i++) begin
      step(1'b0, tbl[i].sel, tbl[i].we, {28'h2000000, tbl[i].off, 2'b00}, tbl[i].data);
      check($sformatf("tbl[%0d]", i), rdata, tbl[i].exp);
    end

    // 0xA5 at BAUDDIV=3: start bit two cycles after the write, 4-cycle bits
    wr(2'd0, 32'hA5);
    check("a5_prestart", 32'(tx), 32'd1);
    for (int b = 0; b < 10; b++) begin
      for (int k = 0; k < 4; k++) begin
        idle(1);
        check($sformatf("a5_bit%0d_%0d", b, k), 32'(tx), 32'(a5_frame[b]));
      end
    end
    check("a5_irq_busy", 32'(irq), 32'd0);
    idle(2);
    check("a5_irq_done", 32'(irq), 32'd1);

    // Overflow with BAUDDIV=0 and a busy FSM
    wr(2'd2, 32'd0);
    idle(2);
    for (int i = 1; i <= 6; i++) wr(2'd0, 32'(i));
    rd(2'd1);
    check("ovf_status", rdata, 32'h0000_040D);
    wr(2'd1, 32'h8);
    rd(2'd1);
    check("ovf_cleared", 32'(rdata[3]), 32'd0);
    idle(70);

    // Push into a full FIFO in the exact cycle IDLE pops
    wr(2'd2, 32'd3);
    for (int i = 0; i < 5; i++) wr(2'd0, 32'h11 + 32'(i));
    for (int i = 0; i < 200 && m_busy(); i++) idle(1);
    check("popsync_wait", 32'(m_busy()), 32'd0);
    wr(2'd0, 32'h99);
    rd(2'd1);
    check("popsync_status", rdata, 32'h0000_0405);
    idle(240);

    // BAUDDIV change mid-frame only affects the next frame
    wr(2'd0, 32'hFF);
    wr(2'd2, 32'd7);
    len = 0;
    for (int i = 0; i < 100 && tx == 1'b0; i++) begin len++; idle(1); end
    check("baud_old_start_len", 32'(len), 32'd4);
    wr(2'd0, 32'h11);
    for (int i = 0; i < 200 && tx == 1'b1; i++) idle(1);
    len = 0;
    for (int i = 0; i < 100 && tx == 1'b0; i++) begin len++; idle(1); end
    check("baud_new_start_len", 32'(len), 32'd8);
    idle(100);

    // Reset in the middle of a frame
    wr(2'd2, 32'd3);
    wr(2'd0, 32'h3C);
    wr(2'd0, 32'h3C);
    idle(12);
    step(1'b1, 1'b0, 4'd0, 32'd0, 32'd0);
    check("midrst_tx", 32'(tx), 32'd1);
    rd(2'd1);
    check("midrst_status", rdata, 32'h0000_0002);

`ifdef RV32_UART_TX_PARITY_EN
    wr(2'd1, 32'h10);
    rd(2'd1);
    check("par_status", rdata, 32'h0000_0012);
    wr(2'd2, 32'd0);
    wr(2'd0, 32'h07);
    idle(10);
    check("par_07", 32'(tx), 32'd1);
    idle(4);
    wr(2'd0, 32'h03);
    idle(10);
    check("par_03", 32'(tx), 32'd0);
    idle(4);
    wr(2'd1, 32'h0);
`else
    wr(2'd1, 32'h10);
    rd(2'd1);
    check("nopar_status", rdata, 32'h0000_0002);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      automatic int unsigned op = $urandom_range(0, 99);
      automatic logic [1:0] off = 2'($urandom_range(0, 3));
      automatic logic [31:0] d = $urandom;
      if (op == 0) begin
        step(1'b1, 1'b0, 4'd0, 32'd0, 32'd0);
      end else if (op < 60) begin
        idle(1);
      end else if (op < 80) begin
        step(1'b0, 1'b1, 4'd0, {28'h2000000, off, 2'b00}, d);
      end else begin
        if (off == 2'd2) d = 32'($urandom_range(0, 5));
        step(1'b0, 1'($urandom_range(0, 7) != 0), 4'($urandom_range(1, 15)),
             {28'h2000000, off, 2'b00}, d);
      end
    end
    idle(400);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
